// File: rtl/pipe_pkg.sv
// Shared definitions for the stream pipeline blocks: mux mode codes and index helpers.
package pipe_pkg;

  localparam int MUX_MODE_SEL = 0;
  localparam int MUX_MODE_RR  = 1;

  // Next index after idx in a ring of n entries.
  function automatic int idx_inc_wrap(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational rotate-priority encoder: first asserted request at or after ptr, wrapping.
module rr_arbiter_n #(
  parameter  int N    = 3,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_v,
  output logic [SELW-1:0] gnt_idx
);

  int   idx;
  logic found;

  assign gnt_v = |req;

  always_comb begin
    idx     = 0;
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N:1 registered stream mux with valid/ready handshake; explicit-select or round-robin grant.
module stream_mux_n
  import pipe_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int N     = 3,
  parameter  int MODE  = MUX_MODE_SEL,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  input  logic               out_ready,
  output logic               sel_err
);

  logic             load;
  logic             gnt_v;
  logic [SELW-1:0]  g;
  logic [WIDTH-1:0] gnt_data;

  assign load = !out_valid || out_ready;

  generate
    if (MODE == MUX_MODE_RR) begin : g_rr
      logic [SELW-1:0] rr_ptr;

      rr_arbiter_n #(.N(N)) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt_v   (gnt_v),
        .gnt_idx (g)
      );

      always_ff @(posedge clk) begin
        if (rst)                 rr_ptr <= '0;
        else if (load && gnt_v)  rr_ptr <= SELW'(idx_inc_wrap(int'(g), N));
      end
    end else begin : g_sel
      // Padded so an out-of-range sel reads a zero instead of aliasing.
      logic [2**SELW-1:0] valid_pad;

      always_comb begin
        valid_pad        = '0;
        valid_pad[N-1:0] = in_valid;
      end

      assign g     = sel;
      assign gnt_v = (int'(sel) < N) && valid_pad[sel];
    end
  endgenerate

  always_comb begin
    gnt_data = '0;
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (g == SELW'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
      in_ready[i] = !rst && load && gnt_v && (g == SELW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      sel_err   <= 1'b0;
    end else begin
      sel_err <= (MODE == MUX_MODE_SEL) && (int'(sel) >= N);
      if (load) begin
        out_valid <= gnt_v;
        if (gnt_v) begin
          out_data <= gnt_data;
          out_src  <= g;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: one explicit-select and one round-robin instance against a cycle model.
module tb_stream_mux_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  in_valid = 3'b111;
  logic [47:0] in_data  = {16'd764, 16'd22, 16'd10};
  logic [1:0]  sel = 2'd0;
  logic        out_ready = 1'b1;

  logic [2:0]  rdy0, rdy1;
  logic        ov0, ov1, se0, se1;
  logic [15:0] od0, od1;
  logic [1:0]  os0, os1;

  int n_cmp = 0;
  int n_bad = 0;

  int m_ov[2]  = '{0, 0};
  int m_od[2]  = '{0, 0};
  int m_os[2]  = '{0, 0};
  int m_se[2]  = '{0, 0};
  int m_ptr[2] = '{0, 0};

  always #5 clk = ~clk;

  stream_mux_n #(.WIDTH(16), .N(3), .MODE(0)) u_sel (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
    .sel(sel), .out_valid(ov0), .out_data(od0), .out_src(os0), .out_ready(out_ready),
    .sel_err(se0)
  );

  stream_mux_n #(.WIDTH(16), .N(3), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
    .sel(sel), .out_valid(ov1), .out_data(od1), .out_src(os1), .out_ready(out_ready),
    .sel_err(se1)
  );

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Channel that wins this cycle under the given mode, or -1 when nobody is granted.
  function automatic int grant(int md, int ptr);
    if (md == 0) begin
      if (sel >= 2'd3) return -1;
      return in_valid[sel] ? int'(sel) : -1;
    end
    for (int k = 0; k < 3; k++)
      if (in_valid[(ptr + k) % 3]) return (ptr + k) % 3;
    return -1;
  endfunction

  function automatic int chan(int i);
    logic [47:0] d;
    d = in_data;
    return int'(d[i*16 +: 16]);
  endfunction

  // Compare registered outputs and in_ready against the model, then advance the model.
  always @(negedge clk) begin
    int ld, g, exp_rdy;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("out_valid[%0d]", d), int'(d == 0 ? ov0 : ov1), m_ov[d]);
      chk($sformatf("out_data[%0d]", d),  int'(d == 0 ? od0 : od1), m_od[d]);
      chk($sformatf("out_src[%0d]", d),   int'(d == 0 ? os0 : os1), m_os[d]);
      chk($sformatf("sel_err[%0d]", d),   int'(d == 0 ? se0 : se1), m_se[d]);
      ld = (m_ov[d] == 0 || out_ready) ? 1 : 0;
      g  = grant(d, m_ptr[d]);
      exp_rdy = (!rst && ld == 1 && g >= 0) ? (1 << g) : 0;
      chk($sformatf("in_ready[%0d]", d), int'(d == 0 ? rdy0 : rdy1), exp_rdy);
      if (rst) begin
        m_ov[d] = 0; m_od[d] = 0; m_os[d] = 0; m_se[d] = 0; m_ptr[d] = 0;
      end else begin
        m_se[d] = (d == 0 && sel >= 2'd3) ? 1 : 0;
        if (ld == 1) begin
          if (g >= 0) begin
            m_ov[d]  = 1;
            m_od[d]  = chan(g);
            m_os[d]  = g;
            m_ptr[d] = (g + 1) % 3;
          end else begin
            m_ov[d] = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset held two clocks with all channels requesting
    tick(); tick();
    chk("rst_in_ready", int'(rdy0), 0);
    chk("rst_out_valid", int'(ov0), 0);
    chk("rst_out_data", int'(od0), 0);
    chk("rst_sel_err", int'(se0), 0);
    chk("rst_in_ready_rr", int'(rdy1), 0);

    // Explicit select walks channels 0,1,2
    rst = 1'b0; sel = 2'd0;
    tick(); chk("sel0_data", int'(od0), 10);  chk("sel0_src", int'(os0), 0);
    sel = 2'd1;
    tick(); chk("sel1_data", int'(od0), 22);  chk("sel1_src", int'(os0), 1);
    sel = 2'd2;
    tick(); chk("sel2_data", int'(od0), 764); chk("sel2_src", int'(os0), 2);

    // Out-of-range select
    sel = 2'd3; #1;
    chk("bad_sel_ready", int'(rdy0), 0);
    tick(); chk("bad_sel_valid", int'(ov0), 0); chk("bad_sel_err", int'(se0), 1);
    sel = 2'd1;
    tick(); chk("recover_data", int'(od0), 22); chk("recover_err", int'(se0), 0);
    chk("recover_valid", int'(ov0), 1);

    // Backpressure holds the word; release reloads with no bubble
    out_ready = 1'b0; sel = 2'd2; in_data = {16'd999, 16'd55, 16'd77}; #1;
    chk("bp_ready", int'(rdy0), 0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("bp_hold_data", int'(od0), 22); chk("bp_hold_valid", int'(ov0), 1);
    end
    out_ready = 1'b1; #1;
    chk("bp_release_ready", int'(rdy0), 3'b100);
    tick(); chk("bp_new_data", int'(od0), 999); chk("bp_new_valid", int'(ov0), 1);
    in_data = {16'd764, 16'd22, 16'd10};

    // Round-robin, all valid, from a fresh pointer
    rst = 1'b1; tick(); chk("rr_rst_valid", int'(ov1), 0);
    rst = 1'b0; in_valid = 3'b111;
    tick(); chk("rr111_a", int'(os1), 0);
    tick(); chk("rr111_b", int'(os1), 1);
    tick(); chk("rr111_c", int'(os1), 2);
    tick(); chk("rr111_d", int'(os1), 0);

    // Round-robin skipping an idle channel
    rst = 1'b1; tick();
    rst = 1'b0; in_valid = 3'b101; #1;
    chk("rr101_ready", int'(rdy1), 3'b001);
    tick(); chk("rr101_a", int'(os1), 0);
    tick(); chk("rr101_b", int'(os1), 2);
    tick(); chk("rr101_c", int'(os1), 0);
    tick(); chk("rr101_d", int'(os1), 2);
    in_valid = 3'b011;
    tick(); chk("rr011", int'(os1), 0);
    in_valid = 3'b000;
    tick(); chk("rr_idle_valid", int'(ov1), 0);
    in_valid = 3'b111;
    tick(); chk("rr_ptr_held", int'(os1), 1); chk("rr_ptr_held_v", int'(ov1), 1);

    // Reset while a word is stalled
    out_ready = 1'b0;
    tick(); chk("stall_valid", int'(ov1), 1); chk("stall_src", int'(os1), 1);
    rst = 1'b1;
    tick(); chk("midrst_valid", int'(ov1), 0); chk("midrst_src", int'(os1), 0);
    chk("midrst_valid_sel", int'(ov0), 0);
    rst = 1'b0; out_ready = 1'b1;
    tick(); chk("post_rst_grant", int'(os1), 0); chk("post_rst_valid", int'(ov1), 1);

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
